slow_memory_param: RTL and testbench

- Parametrised, cycle-accurate successor to the fixed-latency slow memory model that backs the I-cache and D-cache in the CHIP testbench.
- Serves one line-wide read or write request at a time, after a programmable latency.
- Adds byte-strobe writes, protocol-error detection and access statistics, so one model fits any cache line width and depth.
- Used as a behavioural model in the testbench; it is not synthesised into CHIP.

---
 rtl/slow_mem_pkg.sv | 32 +++
 rtl/sat_counter.sv | 26 ++
 rtl/slow_memory_param.sv | 156 +++++++++++++++
 tb/tb_slow_memory_param.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/slow_mem_pkg.sv
// rtl/slow_mem_pkg.sv - shared types, defaults and helpers for the slow memory model
//
// Contents:
//   state_t        request FSM states (IDLE, BUSY, DONE), 2-bit encoding
//   LEGACY_LINE_W  line width of the fixed-latency predecessor
//   LEGACY_ADDR_W  line address width of the fixed-latency predecessor
//   clog2()        ceiling log2 for parameter arithmetic

package slow_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int LEGACY_LINE_W = 128;
    localparam int LEGACY_ADDR_W = 28;

    // Smallest r with (1 << r) >= value; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter for access statistics
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset, clears count
//   inc    in   count one event this cycle
//   count  out  event count, sticks at all-ones instead of wrapping

module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/slow_memory_param.sv
// rtl/slow_memory_param.sv - parametrised fixed-latency line memory with byte strobes and statistics
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   mem_read     read request, held until mem_ready
//   mem_write    write request, held until mem_ready
//   mem_addr     line address; bits at IDX_W and above are ignored (aliasing)
//   mem_wdata    write line
//   mem_wstrb    byte write enables, all-ones = full-line write
//   mem_rdata    registered read line, holds until the next read completes
//   mem_ready    one-cycle completion pulse
//   mem_busy     request in flight (BUSY or DONE)
//   proto_err    sticky protocol error (read+write together, or request dropped mid-flight)
//   rd_cnt       completed reads, saturating
//   wr_cnt       completed writes, saturating

module slow_memory_param
    import slow_mem_pkg::*;
#(
    parameter int LINE_W  = LEGACY_LINE_W,
    parameter int ADDR_W  = LEGACY_ADDR_W,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 8,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [LINE_W-1:0]     mem_wdata,
    input  logic [LINE_W/8-1:0]   mem_wstrb,
    output logic [LINE_W-1:0]     mem_rdata,
    output logic                  mem_ready,
    output logic                  mem_busy,
    output logic                  proto_err,
    output logic [CNT_W-1:0]      rd_cnt,
    output logic [CNT_W-1:0]      wr_cnt
);

    localparam int IDX_W  = clog2(DEPTH);
    localparam int STRB_W = LINE_W / 8;
    localparam int LAT_W  = (LATENCY > 1) ? clog2(LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);

    state_t              state;
    state_t              state_next;
    logic                op_wr;
    logic [IDX_W-1:0]    idx;
    logic [LINE_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [LAT_W-1:0]    lat_cnt;

    logic                accept;
    logic                fire;
    logic                set_err;

    logic [LINE_W-1:0]   mem [DEPTH];

    // High address bits alias onto the array by design.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^mem_addr;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        fire       = 1'b0;
        set_err    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_read && mem_write) begin
                    set_err = 1'b1;
                end else if (mem_read || mem_write) begin
                    accept     = 1'b1;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // The latched request still completes; only the flag records the drop.
                if (!mem_read && !mem_write) begin
                    set_err = 1'b1;
                end
                if (lat_cnt == '0) begin
                    fire       = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // Requests are ignored here so a late-dropping requester is served once.
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign mem_ready = (state == ST_DONE);
    assign mem_busy  = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_wr     <= 1'b0;
            idx       <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            lat_cnt   <= '0;
            mem_rdata <= '0;
            proto_err <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_wr   <= mem_write;
                idx     <= mem_addr[IDX_W-1:0];
                wdata_q <= mem_wdata;
                wstrb_q <= mem_wstrb;
                lat_cnt <= LAT_LOAD;
            end else if ((state == ST_BUSY) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            if (fire && !op_wr) begin
                mem_rdata <= mem[idx];
            end
            if (set_err) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Array is not reset; an asynchronous reset forces IDLE so an aborted write never fires.
    always_ff @(posedge clk) begin
        if (fire && op_wr) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_q[b]) begin
                    mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_rd_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (fire && !op_wr),
        .count (rd_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_wr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (fire && op_wr),
        .count (wr_cnt)
    );

endmodule

// File: tb/tb_slow_memory_param.sv
// tb/tb_slow_memory_param.sv - self-checking bench for slow_memory_param

module tb_slow_memory_param;

    localparam int LAT = 8;
    localparam int LW  = 128;
    localparam int AW  = 28;
    localparam int SW  = 16;
    localparam int CW  = 16;
    localparam int CNT_MAX = (1 << CW) - 1;

    localparam logic [127:0] PA5 = {16{8'hA5}};
    localparam logic [127:0] P3  = 128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF;
    localparam logic [127:0] P2  = 128'h22222222_DEADC0DE_33333333_FEEDFACE;
    localparam logic [127:0] P7  = 128'h77777777_12345678_9ABCDEF0_0BADF00D;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          mem_read = 1'b0, mem_write = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [LW-1:0] mem_wdata = '0;
    logic [SW-1:0] mem_wstrb = '0;
    logic [LW-1:0] mem_rdata;
    logic          mem_ready, mem_busy, proto_err;
    logic [CW-1:0] rd_cnt, wr_cnt;

    logic          b_read = 1'b0, b_write = 1'b0;
    logic [7:0]    b_addr = '0;
    logic [31:0]   b_wdata = '0;
    logic [3:0]    b_wstrb = '0;
    logic [31:0]   b_rdata;
    logic          b_ready, b_busy, b_err;
    logic [1:0]    b_rd, b_wr;

    slow_memory_param dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_busy(mem_busy),
        .proto_err(proto_err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    slow_memory_param #(
        .LINE_W(32), .ADDR_W(8), .DEPTH(16), .LATENCY(1), .CNT_W(2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .mem_read(b_read), .mem_write(b_write),
        .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_wstrb(b_wstrb),
        .mem_rdata(b_rdata), .mem_ready(b_ready), .mem_busy(b_busy),
        .proto_err(b_err), .rd_cnt(b_rd), .wr_cnt(b_wr)
    );

    int vectors = 0;
    int miscompares = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a request accepted at cycle c completes at c+LAT,
    // is visible as ready for one cycle, and the next cycle is dead time.
    int           cyc = 0;
    int           done_cyc = 0;
    bit           in_flight = 1'b0;
    bit           ready_phase = 1'b0;
    bit           m_is_wr = 1'b0;
    int           m_idx = 0;
    logic [127:0] m_wdata = '0;
    logic [15:0]  m_wstrb = '0;
    logic [127:0] m_rdata = '0;
    bit           m_err = 1'b0;
    int           m_rd = 0;
    int           m_wr = 0;
    logic [127:0] model_mem [256];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight   = 1'b0;
            ready_phase = 1'b0;
            m_rdata     = '0;
            m_err       = 1'b0;
            m_rd        = 0;
            m_wr        = 0;
        end else begin
            cyc++;
            if (ready_phase) begin
                ready_phase = 1'b0;
            end else if (in_flight) begin
                if (!mem_read && !mem_write) m_err = 1'b1;
                if (cyc == done_cyc) begin
                    if (m_is_wr) begin
                        for (int b = 0; b < 16; b++)
                            if (m_wstrb[b]) model_mem[m_idx][8*b +: 8] = m_wdata[8*b +: 8];
                        m_wr = (m_wr == CNT_MAX) ? CNT_MAX : m_wr + 1;
                    end else begin
                        m_rdata = model_mem[m_idx];
                        m_rd = (m_rd == CNT_MAX) ? CNT_MAX : m_rd + 1;
                    end
                    in_flight   = 1'b0;
                    ready_phase = 1'b1;
                end
            end else if (mem_read && mem_write) begin
                m_err = 1'b1;
            end else if (mem_read || mem_write) begin
                in_flight = 1'b1;
                done_cyc  = cyc + LAT;
                m_is_wr   = mem_write;
                m_idx     = int'(mem_addr) % 256;
                m_wdata   = mem_wdata;
                m_wstrb   = mem_wstrb;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            check("cyc_ready", mem_ready, ready_phase);
            check("cyc_busy", mem_busy, in_flight || ready_phase);
            check("cyc_err", proto_err, m_err);
            check("cyc_rdata", mem_rdata, m_rdata);
            check("cyc_rd_cnt", rd_cnt, m_rd);
            check("cyc_wr_cnt", wr_cnt, m_wr);
        end
    end

    task automatic do_req(input bit rd, input bit wr, input int addr, input logic [127:0] wd,
                          input logic [15:0] ws, output int edges);
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_addr = AW'(addr); mem_wdata = wd; mem_wstrb = ws;
        edges = 0;
        while (!mem_ready && edges < 50) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("ready_seen", mem_ready, 1'b1);
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic do_req2(input bit rd, input bit wr, input int addr, input logic [31:0] wd,
                           output int edges);
        @(negedge clk);
        b_read = rd; b_write = wr; b_addr = 8'(addr); b_wdata = wd; b_wstrb = 4'hF;
        edges = 0;
        while (!b_ready && edges < 50) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("b_ready_seen", b_ready, 1'b1);
        b_read = 1'b0; b_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int l;
        int pulses;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdata", mem_rdata, 0);
        check("reset_ready", mem_ready, 0);
        check("reset_busy", mem_busy, 0);
        check("reset_err", proto_err, 0);
        check("reset_rd_cnt", rd_cnt, 0);
        check("reset_wr_cnt", wr_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        do_req(0, 1, 5, PA5, '1, l);
        do_req(0, 1, 3, P3, '1, l);
        do_req(0, 1, 2, P2, '1, l);
        do_req(0, 1, 7, P7, '1, l);
        check("preload_wr_cnt", wr_cnt, 4);

        do_req(1, 0, 5, '0, '0, l);
        check("read5_latency_edges", l, 9);
        check("read5_data", mem_rdata, PA5);
        check("read5_rd_cnt", rd_cnt, 1);

        do_req(0, 1, 3, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 16'h00FF, l);
        check("partial_wr_cnt", wr_cnt, 5);
        do_req(1, 0, 3, '0, '0, l);
        check("partial_data", mem_rdata, 128'hCAFEBABE_DEADBEEF_07060504_03020100);

        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b1;
        pulses = 0;
        repeat (2 * LAT) begin
            @(negedge clk);
            if (mem_ready) pulses++;
        end
        mem_read = 1'b0; mem_write = 1'b0;
        check("both_err", proto_err, 1);
        check("both_no_ready", pulses, 0);
        check("both_rd_cnt", rd_cnt, 2);
        check("both_wr_cnt", wr_cnt, 5);

        do_req(1, 0, 258, '0, '0, l);
        check("alias_data", mem_rdata, P2);

        @(negedge clk);
        mem_read = 1'b1; mem_addr = AW'(5);
        pulses = 0;
        repeat (LAT + 2) begin
            @(negedge clk);
            if (mem_ready) pulses++;
        end
        mem_read = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (mem_ready) pulses++;
        end
        check("hold_pulses", pulses, 1);
        check("hold_rd_cnt", rd_cnt, 4);
        check("hold_busy_after", mem_busy, 0);
        do_req(1, 0, 2, '0, '0, l);
        check("next_accept_latency", l, 9);
        check("next_accept_data", mem_rdata, P2);

        @(negedge clk);
        mem_write = 1'b1; mem_addr = AW'(7); mem_wdata = ~P7; mem_wstrb = '1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_ready", mem_ready, 0);
        check("abort_busy", mem_busy, 0);
        check("abort_err", proto_err, 0);
        check("abort_rdata", mem_rdata, 0);
        check("abort_rd_cnt", rd_cnt, 0);
        check("abort_wr_cnt", wr_cnt, 0);
        mem_write = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_req(1, 0, 7, '0, '0, l);
        check("after_abort_data", mem_rdata, P7);
        check("after_abort_rd_cnt", rd_cnt, 1);
        check("after_abort_latency", l, 9);

        do_req2(0, 1, 1, 32'h12345678, l);
        check("b_write_latency", l, 2);
        check("b_wr_cnt", b_wr, 1);
        for (int i = 0; i < 5; i++) begin
            do_req2(1, 0, (i == 4) ? 17 : 1, '0, l);
            check("b_read_latency", l, 2);
            check("b_read_data", b_rdata, 32'h12345678);
            check("b_rd_cnt_sat", b_rd, (i + 1 > 3) ? 3 : i + 1);
        end
        check("b_err", b_err, 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
